breadboard_sweep_ctrl: RTL and testbench

//  Sequencer for the 4-input breadboard logic block (inputs w,x,y,z; outputs f2,f3,f4,f7).
//  On start it drives all 16 input vectors (0..15, w=MSB) and waits a settle time for each.
//  It samples the block outputs and compares them against a golden table.
//  It logs each result and reports a pass/fail summary with error count. It replaces the hand-run sweep loop.

---
 rtl/breadboard_sweep_ctrl_if.sv | 25 ++
 rtl/breadboard_sweep_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_breadboard_sweep_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/breadboard_sweep_ctrl_if.sv
// ----------------------------------------------------------------------------
// breadboard_sweep_ctrl_if
//   Probe bus between the sweep sequencer and the 4-input breadboard block.
//   dut_w/x/y/z : input vector applied to the block (w = MSB)
//   dut_f       : block response {f2,f3,f4,f7}
//   master : sequencer side (drives the vector, observes the response)
//   slave  : block side (receives the vector, returns the response)
// ----------------------------------------------------------------------------
interface breadboard_sweep_ctrl_if;
  logic       dut_w;
  logic       dut_x;
  logic       dut_y;
  logic       dut_z;
  logic [3:0] dut_f;

  modport master (
    output dut_w, dut_x, dut_y, dut_z,
    input  dut_f
  );

  modport slave (
    input  dut_w, dut_x, dut_y, dut_z,
    output dut_f
  );
endinterface

// File: rtl/breadboard_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// breadboard_sweep_ctrl
//   Walks the breadboard logic block through all 16 input vectors, waits a
//   settle time after each drive, compares the response with a golden table,
//   logs every sample and reports a pass/fail summary.
//
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      begin a sweep (IDLE only) / cancel a sweep
//   bb (master)       vector out to the block, response {f2,f3,f4,f7} back
//   busy              sweep in progress (DRIVE/SETTLE/SAMPLE)
//   done, pass        end-of-sweep pulse / no mismatches in the last sweep
//   err_count         mismatching vectors this sweep (0..16)
//   first_err_valid/_idx  first mismatching vector of this sweep
//   log_valid/_idx/_obs/_mismatch  one record per sampled vector
// ----------------------------------------------------------------------------
module breadboard_sweep_ctrl #(
  parameter int          SETTLE_CYCLES = 4,     // 1..255
  parameter bit          STOP_ON_ERR   = 1'b0,
  parameter logic [63:0] EXP_TABLE     = 64'hE4C1_E150_E510_3800
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  breadboard_sweep_ctrl_if.master        bb,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [4:0]                     err_count,
  output logic                           first_err_valid,
  output logic [3:0]                     first_err_idx,
  output logic                           log_valid,
  output logic [3:0]                     log_idx,
  output logic [3:0]                     log_obs,
  output logic                           log_mismatch
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly
  // SETTLE_CYCLES cycles, including the cycle in which it reaches zero.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] idx;
  logic [7:0] cnt;
  logic [3:0] vec;
  logic [3:0] exp_f;
  logic       mismatch;

  logic do_accept;
  logic do_drive;
  logic do_settle;
  logic do_sample;
  logic do_done;
  logic do_abort;

  assign bb.dut_w = vec[3];
  assign bb.dut_x = vec[2];
  assign bb.dut_y = vec[1];
  assign bb.dut_z = vec[0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-state action strobes
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    do_accept  = 1'b0;
    do_drive   = 1'b0;
    do_settle  = 1'b0;
    do_sample  = 1'b0;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    exp_f      = EXP_TABLE[{idx, 2'b00} +: 4];
    mismatch   = (bb.dut_f != exp_f);

    unique case (state)
      IDLE: begin
        // abort wins over start when both are seen in IDLE
        if (start && !abort) begin
          do_accept  = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        do_drive   = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        do_settle = 1'b1;
        if (cnt == 8'd0) state_next = SAMPLE;
      end
      SAMPLE: begin
        do_sample = 1'b1;
        if (idx == 4'd15 || (STOP_ON_ERR && mismatch)) state_next = DONE;
        else                                          state_next = DRIVE;
      end
      DONE: begin
        do_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // abort overrides whatever the current state would have done this edge,
    // so a sample cut short by abort is neither logged nor counted
    if (abort && state != IDLE) begin
      do_drive   = 1'b0;
      do_settle  = 1'b0;
      do_sample  = 1'b0;
      do_done    = 1'b0;
      do_abort   = 1'b1;
      state_next = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= 4'd0;
      cnt             <= 8'd0;
      vec             <= 4'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= 5'd0;
      first_err_valid <= 1'b0;
      first_err_idx   <= 4'd0;
      log_valid       <= 1'b0;
      log_idx         <= 4'd0;
      log_obs         <= 4'd0;
      log_mismatch    <= 1'b0;
    end else begin
      // pulses default low; log_idx/obs/mismatch hold their last record
      log_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= (state_next == DRIVE) || (state_next == SETTLE) ||
                   (state_next == SAMPLE);

      if (do_accept) begin
        idx             <= 4'd0;
        err_count       <= 5'd0;
        first_err_valid <= 1'b0;
        first_err_idx   <= 4'd0;
        pass            <= 1'b0;
      end

      if (do_drive) begin
        vec <= idx;
        cnt <= SETTLE_LOAD;
      end

      if (do_settle && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end

      if (do_sample) begin
        log_valid    <= 1'b1;
        log_idx      <= idx;
        log_obs      <= bb.dut_f;
        log_mismatch <= mismatch;
        if (mismatch) begin
          // at most 16 samples per sweep, so this never exceeds 16
          err_count <= err_count + 5'd1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= idx;
          end
        end
        if (state_next == DRIVE) idx <= idx + 4'd1;
      end

      if (do_done) begin
        done <= 1'b1;
        pass <= (err_count == 5'd0);
        vec  <= 4'd0;
      end

      if (do_abort) begin
        pass <= 1'b0;
        vec  <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_breadboard_sweep_ctrl
//   Bench for breadboard_sweep_ctrl. dut0 uses default parameters, dut1 runs
//   with STOP_ON_ERR=1. Each controller drives a behavioural breadboard block
//   (golden table with an optional injected fault). Expected log records are
//   queued when a sweep is launched and popped by a monitor on log_valid.
// ----------------------------------------------------------------------------
module tb_breadboard_sweep_ctrl;

  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] obs;
    logic       mm;
  } log_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // golden block response {f2,f3,f4,f7} for vectors 0..15
  logic [3:0] gold [16] = '{4'h0, 4'h0, 4'h8, 4'h3, 4'h0, 4'h1, 4'h5, 4'hE,
                            4'h0, 4'h5, 4'h1, 4'hE, 4'h1, 4'hC, 4'h4, 4'hE};

  // fault modes: 0 none, 1 f7 stuck at 0, 2 f2 inverted
  int fault_mode = 0;

  function automatic logic [3:0] faulty(int mode, logic [3:0] g);
    case (mode)
      1:       return g & 4'hE;
      2:       return g ^ 4'h8;
      default: return g;
    endcase
  endfunction

  // dut0 signals
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic       busy0, done0, pass0, fev0, lv0, lmm0;
  logic [4:0] err0;
  logic [3:0] fidx0, lidx0, lobs0, vec0;

  // dut1 signals
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic       busy1, done1, pass1, fev1, lv1, lmm1;
  logic [4:0] err1;
  logic [3:0] fidx1, lidx1, lobs1, vec1;

  breadboard_sweep_ctrl_if bb0 ();
  breadboard_sweep_ctrl_if bb1 ();

  assign vec0     = {bb0.dut_w, bb0.dut_x, bb0.dut_y, bb0.dut_z};
  assign vec1     = {bb1.dut_w, bb1.dut_x, bb1.dut_y, bb1.dut_z};
  assign bb0.dut_f = faulty(fault_mode, gold[vec0]);
  assign bb1.dut_f = faulty(2, gold[vec1]);

  breadboard_sweep_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .bb(bb0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_valid(fev0), .first_err_idx(fidx0), .log_valid(lv0),
    .log_idx(lidx0), .log_obs(lobs0), .log_mismatch(lmm0)
  );

  breadboard_sweep_ctrl #(.STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .bb(bb1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_idx(fidx1), .log_valid(lv1),
    .log_idx(lidx1), .log_obs(lobs1), .log_mismatch(lmm1)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  log_t q0[$];
  log_t q1[$];
  log_t e0, e1;

  task automatic push_exp(int which, int first, int n, int mode);
    log_t e;
    for (int i = first; i < first + n; i++) begin
      e.idx = 4'(i);
      e.obs = faulty(mode, gold[i]);
      e.mm  = (e.obs != gold[i]);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endtask

  task automatic unexpected_log(string tag, logic [3:0] idx);
    vectors++;
    miscompares++;
    $display("FAIL %s_unexpected_log: got record idx %0d expected no record", tag, idx);
  endtask

  always @(negedge clk) begin
    if (lv0) begin
      if (q0.size() == 0) unexpected_log("dut0", lidx0);
      else begin
        e0 = q0.pop_front();
        check("dut0_log_idx", 32'(lidx0), 32'(e0.idx));
        check("dut0_log_obs", 32'(lobs0), 32'(e0.obs));
        check("dut0_log_mismatch", 32'(lmm0), 32'(e0.mm));
        check("dut0_vec_at_log", 32'(vec0), 32'(e0.idx));
      end
    end
    if (lv1) begin
      if (q1.size() == 0) unexpected_log("dut1", lidx1);
      else begin
        e1 = q1.pop_front();
        check("dut1_log_idx", 32'(lidx1), 32'(e1.idx));
        check("dut1_log_obs", 32'(lobs1), 32'(e1.obs));
        check("dut1_log_mismatch", 32'(lmm1), 32'(e1.mm));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic do_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("dut0_busy_after_accept", 32'(busy0), 32'd1);
  endtask

  // counts edges after the accept edge until done is seen; -1 on timeout
  task automatic wait_done0(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic wait_done1(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic full_pass_sweep0(string tag);
    int cyc;
    fault_mode = 0;
    push_exp(0, 0, 16, 0);
    do_start0();
    wait_done0(cyc);
    check({tag, "_done_latency"}, 32'(cyc), 32'd97);
    check({tag, "_pass"}, 32'(pass0), 32'd1);
    check({tag, "_err_count"}, 32'(err0), 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int cyc;
    int seen;

    // reset state
    #22;
    check("reset_outputs", 32'({busy0, done0, pass0, err0, fev0, fidx0, lv0,
                               lidx0, lobs0, lmm0, vec0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: golden block, full sweep
    full_pass_sweep0("t1");
    check("t1_first_err_valid", 32'(fev0), 32'd0);
    check("t1_vec_after_done", 32'(vec0), 32'd0);
    check("t1_busy_at_done", 32'(busy0), 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_one_cycle", 32'(done0), 32'd0);
    check("t1_pass_held", 32'(pass0), 32'd1);

    // 2: f7 stuck at 0
    fault_mode = 1;
    push_exp(0, 0, 16, 1);
    do_start0();
    wait_done0(cyc);
    check("t2_done_latency", 32'(cyc), 32'd97);
    check("t2_err_count", 32'(err0), 32'd6);
    check("t2_first_err_valid", 32'(fev0), 32'd1);
    check("t2_first_err_idx", 32'(fidx0), 32'd3);
    check("t2_pass", 32'(pass0), 32'd0);
    fault_mode = 0;

    // 3: STOP_ON_ERR with f2 inverted, stops after vector 0
    push_exp(1, 0, 1, 2);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_done1(cyc);
    check("t3_done_latency", 32'(cyc), 32'd7);
    check("t3_err_count", 32'(err1), 32'd1);
    check("t3_first_err", 32'({fev1, fidx1}), 32'h10);
    check("t3_pass", 32'(pass1), 32'd0);
    check("t3_busy", 32'(busy1), 32'd0);

    // 4: abort while vector 7 is settling, then a clean restart
    push_exp(0, 0, 7, 0);
    do_start0();
    repeat (43) @(posedge clk);
    #1;
    check("t4_vec_before_abort", 32'(vec0), 32'd7);
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    abort0 = 1'b0;
    check("t4_busy_after_abort", 32'(busy0), 32'd0);
    check("t4_vec_after_abort", 32'(vec0), 32'd0);
    check("t4_done_after_abort", 32'(done0), 32'd0);
    check("t4_pass_after_abort", 32'(pass0), 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done0 || busy0) seen++;
    end
    check("t4_quiet_after_abort", 32'(seen), 32'd0);
    full_pass_sweep0("t4_restart");

    // 5: reset pulse in the middle of SETTLE
    do_start0();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_reset_outputs", 32'({busy0, done0, pass0, err0, fev0, fidx0,
                                        lv0, lidx0, lobs0, lmm0, vec0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_pass_sweep0("t5_after_reset");

    // 6: start held through a whole sweep
    push_exp(0, 0, 16, 0);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    wait_done0(cyc);
    check("t6_single_sweep_latency", 32'(cyc), 32'd97);
    check("t6_busy_at_done", 32'(busy0), 32'd0);
    @(posedge clk);
    #1;
    check("t6_reaccept_first_idle", 32'(busy0), 32'd1);
    start0 = 1'b0;
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    abort0 = 1'b0;
    check("t6_abort_second_sweep", 32'(busy0), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
